// File: rtl/fma_scheduler_if.sv
// fma_scheduler_if: bundle of requester-side and FMA-side signals around the
// shared FMA scheduler.
//   master : the scheduler (accepts requests, issues to the FMA, responds)
//   slave  : the attached environment (requesters and the FMA instance)
// Requester operands are packed, slice i belonging to requester i.
interface fma_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned FP   = 32
);
  localparam int unsigned GBITS = $clog2(NREQ);

  // requester side
  logic [NREQ-1:0]    req_valid_in;
  logic [NREQ*FP-1:0] req_a_in;
  logic [NREQ*FP-1:0] req_b_in;
  logic [NREQ*FP-1:0] req_c_in;
  logic [NREQ-1:0]    req_ready_out;
  logic [NREQ-1:0]    resp_valid_out;
  logic [FP-1:0]      resp_data_out;
  logic               resp_overflow_out;
  logic               resp_underflow_out;
  logic               resp_error_out;
  logic [GBITS-1:0]   grant_out;

  // FMA side
  logic               fma_req_out;
  logic [FP-1:0]      fma_a_out;
  logic [FP-1:0]      fma_b_out;
  logic [FP-1:0]      fma_c_out;
  logic               fma_busy_in;
  logic               fma_ready_answer_in;
  logic [FP-1:0]      fma_answer_in;
  logic               fma_overflow_in;
  logic               fma_underflow_in;

  modport master (
    input  req_valid_in, req_a_in, req_b_in, req_c_in,
    output req_ready_out, resp_valid_out, resp_data_out,
    output resp_overflow_out, resp_underflow_out, resp_error_out, grant_out,
    output fma_req_out, fma_a_out, fma_b_out, fma_c_out,
    input  fma_busy_in, fma_ready_answer_in, fma_answer_in,
    input  fma_overflow_in, fma_underflow_in
  );

  modport slave (
    output req_valid_in, req_a_in, req_b_in, req_c_in,
    input  req_ready_out, resp_valid_out, resp_data_out,
    input  resp_overflow_out, resp_underflow_out, resp_error_out, grant_out,
    input  fma_req_out, fma_a_out, fma_b_out, fma_c_out,
    output fma_busy_in, fma_ready_answer_in, fma_answer_in,
    output fma_overflow_in, fma_underflow_in
  );
endinterface

// File: rtl/fma_scheduler.sv
// fma_scheduler: shares one FMA unit (a*b+c) between NREQ requesters.
// Round-robin grant, one operation in flight, watchdog error response if the
// FMA does not answer within TIMEOUT cycles of ISSUE+WAIT.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - asynchronous active-high reset
//   bus  - fma_scheduler_if.master: requester valid/operands in, one-hot
//          ready/response pulses, result and flags out, grant index, and the
//          FMA issue/answer handshake. All outputs are registered.
module fma_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned FP      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  fma_scheduler_if.master bus
);

  localparam int unsigned GBITS = $clog2(NREQ);
  localparam int unsigned WDW   = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]   WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GBITS-1:0] PTR_INIT = GBITS'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GBITS-1:0] ptr_q, ptr_d;
  logic [GBITS-1:0] grant_q, grant_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [FP-1:0]    a_q, a_d;
  logic [FP-1:0]    b_q, b_d;
  logic [FP-1:0]    c_q, c_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [FP-1:0]    resp_data_q, resp_data_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             err_q, err_d;
  logic             fma_req_q, fma_req_d;

  logic             pick_found;
  logic [GBITS-1:0] pick_idx;

  function automatic logic [NREQ-1:0] onehot(input logic [GBITS-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first pending requester above ptr, wrapping around.
  always_comb begin : arbiter
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      if (!pick_found &&
          bus.req_valid_in[GBITS'((32'(ptr_q) + off) % NREQ)]) begin
        pick_found = 1'b1;
        pick_idx   = GBITS'((32'(ptr_q) + off) % NREQ);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin : next_logic
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_data_d  = '0;
    ovf_d        = 1'b0;
    udf_d        = 1'b0;
    err_d        = 1'b0;
    fma_req_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Operands are captured here so later requester changes cannot leak in.
        if (pick_found && !bus.fma_busy_in) begin
          grant_d     = pick_idx;
          a_d         = bus.req_a_in[32'(pick_idx) * FP +: FP];
          b_d         = bus.req_b_in[32'(pick_idx) * FP +: FP];
          c_d         = bus.req_c_in[32'(pick_idx) * FP +: FP];
          wd_d        = '0;
          req_ready_d = onehot(pick_idx);
          fma_req_d   = 1'b1;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (wd_q == WD_LAST) begin
          state_d      = RESPOND;
          resp_valid_d = onehot(grant_q);
          err_d        = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
          if (bus.fma_busy_in) begin
            state_d = WAIT;
          end else begin
            fma_req_d = 1'b1;
          end
        end
      end

      WAIT: begin
        // An answer in the expiry cycle takes priority over the watchdog.
        if (bus.fma_ready_answer_in) begin
          state_d      = RESPOND;
          resp_valid_d = onehot(grant_q);
          resp_data_d  = bus.fma_answer_in;
          ovf_d        = bus.fma_overflow_in;
          udf_d        = bus.fma_underflow_in;
        end else if (wd_q == WD_LAST) begin
          state_d      = RESPOND;
          resp_valid_d = onehot(grant_q);
          err_d        = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end

      RESPOND: begin
        ptr_d   = grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_INIT;
      grant_q      <= '0;
      wd_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
      err_q        <= 1'b0;
      fma_req_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      wd_q         <= wd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
      err_q        <= err_d;
      fma_req_q    <= fma_req_d;
    end
  end

  assign bus.req_ready_out      = req_ready_q;
  assign bus.resp_valid_out     = resp_valid_q;
  assign bus.resp_data_out      = resp_data_q;
  assign bus.resp_overflow_out  = ovf_q;
  assign bus.resp_underflow_out = udf_q;
  assign bus.resp_error_out     = err_q;
  assign bus.grant_out          = grant_q;
  assign bus.fma_req_out        = fma_req_q;
  assign bus.fma_a_out          = a_q;
  assign bus.fma_b_out          = b_q;
  assign bus.fma_c_out          = c_q;

  // Accept and response pulses never address more than one requester.
  a_ready_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(req_ready_q));
  a_resp_onehot : assert property (@(posedge clk) disable iff (rst)
    $onehot0(resp_valid_q));

endmodule

// File: tb/tb_fma_scheduler.sv
// tb_fma_scheduler: directed test of fma_scheduler with a behavioural FMA model.
module tb_fma_scheduler;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned FP      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  fma_scheduler_if #(.NREQ(NREQ), .FP(FP)) bus ();

  fma_scheduler #(.NREQ(NREQ), .FP(FP), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // FMA model controls (written only by the main sequence)
  logic        hold_busy = 1'b0;
  logic        silent    = 1'b0;
  logic        force_en  = 1'b0;
  logic        f_ovf     = 1'b0;
  logic        f_udf     = 1'b0;
  logic [31:0] f_ans     = '0;
  int          lat       = 1;

  // FMA model state (written only by the model)
  logic        m_busy   = 1'b0;
  logic        m_ready  = 1'b0;
  logic        m_ovf    = 1'b0;
  logic        m_udf    = 1'b0;
  logic        m_active = 1'b0;
  logic [31:0] m_ans    = '0;
  int          m_cnt    = 0;

  assign bus.fma_busy_in         = m_busy | hold_busy;
  assign bus.fma_ready_answer_in = m_ready;
  assign bus.fma_answer_in       = m_ans;
  assign bus.fma_overflow_in     = m_ovf;
  assign bus.fma_underflow_in    = m_udf;

  // FMA stand-in: accepts on fma_req_out, answers lat cycles later with
  // a + 2b + 4c (or a forced value), or never when silent.
  always @(negedge clk) begin
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    if (rst) begin
      m_busy   = 1'b0;
      m_active = 1'b0;
      m_cnt    = 0;
    end else if (!m_active) begin
      if (bus.fma_req_out && !hold_busy) begin
        m_active = 1'b1;
        m_busy   = 1'b1;
        m_cnt    = 0;
        m_ans    = force_en ? f_ans :
                   bus.fma_a_out + (bus.fma_b_out << 1) + (bus.fma_c_out << 2);
      end
    end else if (!silent) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == lat) begin
        m_ready  = 1'b1;
        m_busy   = 1'b0;
        m_active = 1'b0;
        m_ovf    = force_en & f_ovf;
        m_udf    = force_en & f_udf;
      end
    end
  end

  logic [31:0] op_a [4];
  logic [31:0] op_b [4];
  logic [31:0] op_c [4];
  logic [31:0] exp_rr [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_operands();
    for (int i = 0; i < 4; i++) begin
      bus.req_a_in[i*32 +: 32] = op_a[i];
      bus.req_b_in[i*32 +: 32] = op_b[i];
      bus.req_c_in[i*32 +: 32] = op_c[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_in = '0;
    set_operands();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One operation: grant expected on the next edge, response rel cycles after
  // the first ISSUE cycle, then an idle cycle with no pulses.
  task automatic expect_op(input string tag, input int exp_idx, input logic [31:0] exp_data,
                           input logic [2:0] exp_flags, input int exp_rel, input logic drop);
    logic       seen;
    int         n;
    logic [3:0] oh;
    oh   = 4'b0001 << exp_idx;
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.req_ready_out != '0) begin
        seen = 1'b1;
        n    = i;
      end
    end
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_grant_lat"}, 32'(n), 32'd1);
    check({tag, "_ready"}, 32'(bus.req_ready_out), 32'(oh));
    check({tag, "_grant"}, 32'(bus.grant_out), 32'(exp_idx));
    check({tag, "_fma_req"}, 32'(bus.fma_req_out), 32'd1);
    if (drop) begin
      bus.req_valid_in = '0;
      bus.req_a_in = '1;
      bus.req_b_in = '1;
      bus.req_c_in = '1;
    end
    seen = 1'b0;
    n    = 0;
    for (int j = 1; j <= 60 && !seen; j++) begin
      @(posedge clk); #1;
      if (bus.resp_valid_out != '0) begin
        seen = 1'b1;
        n    = j;
      end
    end
    check({tag, "_resp_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, "_resp_valid"}, 32'(bus.resp_valid_out), 32'(oh));
    check({tag, "_resp_data"}, bus.resp_data_out, exp_data);
    check({tag, "_flags"},
          32'({bus.resp_error_out, bus.resp_underflow_out, bus.resp_overflow_out}),
          32'(exp_flags));
    check({tag, "_rel"}, 32'(n), 32'(exp_rel));
    @(posedge clk); #1;
    check({tag, "_idle_pulses"}, 32'({bus.resp_valid_out, bus.req_ready_out}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0] acc;
    op_a = '{32'h40000000, 32'h00002000, 32'h00003000, 32'h00004000};
    op_b = '{32'h40400000, 32'h00000002, 32'h00000003, 32'h00000004};
    op_c = '{32'h3F800000, 32'h00000010, 32'h00000010, 32'h00000010};
    // a + 2b + 4c per requester, mod 2^32
    exp_rr = '{32'hBE800000, 32'h00002044, 32'h00003046, 32'h00004048};
    bus.req_valid_in = '0;
    set_operands();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready_out), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid_out), 32'd0);
    check("rst_grant", 32'(bus.grant_out), 32'd0);
    check("rst_fma_req", 32'(bus.fma_req_out), 32'd0);
    check("rst_fma_a", bus.fma_a_out, 32'd0);
    check("rst_resp_data", bus.resp_data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single op: 2.0*3.0+1.0 = 7.0, FMA takes 5 cycles
    lat = 5; force_en = 1'b1; f_ans = 32'h40E00000; f_ovf = 1'b0; f_udf = 1'b0;
    bus.req_valid_in = 4'b0001;
    expect_op("single", 0, 32'h40E00000, 3'b000, 6, 1'b1);
    check("latched_a", bus.fma_a_out, 32'h40000000);
    check("latched_b", bus.fma_b_out, 32'h40400000);
    check("latched_c", bus.fma_c_out, 32'h3F800000);

    // round robin, minimum round trip
    do_reset();
    force_en = 1'b0; lat = 1;
    bus.req_valid_in = 4'b1111;
    for (int k = 0; k < 8; k++)
      expect_op($sformatf("rr%0d", k), k % 4, exp_rr[k % 4], 3'b000, 2, 1'b0);
    bus.req_valid_in = '0;

    // busy gating
    do_reset();
    lat = 2; hold_busy = 1'b1;
    bus.req_valid_in = 4'b0010;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acc = acc | bus.req_ready_out | {3'b000, bus.fma_req_out};
    end
    check("busy_gate_no_grant", 32'(acc), 32'd0);
    hold_busy = 1'b0;
    expect_op("busy_release", 1, exp_rr[1], 3'b000, 3, 1'b1);

    // flags routed to the granted requester
    do_reset();
    force_en = 1'b1; lat = 3; f_ans = 32'h7F800000; f_ovf = 1'b1; f_udf = 1'b0;
    bus.req_valid_in = 4'b0100;
    expect_op("ovf", 2, 32'h7F800000, 3'b001, 4, 1'b1);
    f_ans = 32'h00000001; f_ovf = 1'b0; f_udf = 1'b1;
    set_operands();
    bus.req_valid_in = 4'b0001;
    expect_op("udf", 0, 32'h00000001, 3'b010, 4, 1'b1);

    // watchdog: no answer
    do_reset();
    force_en = 1'b0; f_udf = 1'b0; silent = 1'b1; lat = 1;
    bus.req_valid_in = 4'b0001;
    expect_op("timeout", 0, 32'h0, 3'b100, 16, 1'b1);

    // answer in the expiry cycle wins
    do_reset();
    silent = 1'b0; lat = 15;
    bus.req_valid_in = 4'b0001;
    expect_op("expiry_answer", 0, exp_rr[0], 3'b000, 16, 1'b1);

    // answer one cycle late: error, late answer ignored
    lat = 16;
    set_operands();
    bus.req_valid_in = 4'b0001;
    expect_op("late_answer", 0, 32'h0, 3'b100, 16, 1'b1);
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      acc = acc | bus.resp_valid_out;
    end
    check("late_answer_ignored", 32'(acc), 32'd0);

    // reset in WAIT aborts silently
    do_reset();
    lat = 10;
    bus.req_valid_in = 4'b1111;
    @(posedge clk); #1;
    check("mid_rst_first_ready", 32'(bus.req_ready_out), 32'b0001);
    repeat (3) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("mid_rst_outputs",
          32'({bus.req_ready_out, bus.resp_valid_out, bus.fma_req_out, bus.grant_out,
               bus.resp_error_out}), 32'd0);
    check("mid_rst_fma_a", bus.fma_a_out, 32'd0);
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      acc = acc | bus.resp_valid_out;
    end
    check("mid_rst_no_resp", 32'(acc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expect_op("after_rst", 0, exp_rr[0], 3'b000, 11, 1'b0);
    bus.req_valid_in = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
